// File: rtl/imm_stage_ctrl.sv
// Purpose: decode-stage immediate slicer plus two-entry skid buffer feeding ID/EX.
// Latency: one cycle from accept to out_* when the buffer is empty; one instruction per cycle.
// Backpressure: a stall parks the in-flight word in the skid entry; in_ready_o drops after the edge that fills the buffer.
//
// Ports:
//   clk_i, rst_n_i            pipeline clock, async active-low reset
//   flush_i                   discards buffered and incoming instructions
//   in_valid_i/in_ready_o     IF/ID handshake (in_ready_o registered), in_instr_i word
//   ext_imm_o/ext_type_o      field and opcode to the sign extender; ext_imm_i its result
//   out_valid_o/out_ready_i   ID/EX handshake; out_instr_o, out_imm_o, out_illegal_o head entry
//   stall_cnt_o               saturating count of stalled head cycles
module imm_stage_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  input  logic [XLEN-1:0] in_instr_i,
  output logic            in_ready_o,
  output logic [11:0]     ext_imm_o,
  output logic [6:0]      ext_type_o,
  input  logic [XLEN-1:0] ext_imm_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic            out_illegal_o,
  input  logic            out_ready_i,
  output logic [15:0]     stall_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic            in_ready_q;

  // Entry 0 is the head driven onto out_*, entry 1 is the skid slot.
  logic [XLEN-1:0] head_instr_q;
  logic [XLEN-1:0] head_imm_q;
  logic            head_ill_q;
  logic [XLEN-1:0] skid_instr_q;
  logic [XLEN-1:0] skid_imm_q;
  logic            skid_ill_q;

  logic [15:0]     stall_cnt_q;

  logic [6:0]      opcode;
  logic            in_illegal;
  logic            accept;
  logic            deliver;
  logic            load_head_in;
  logic            load_head_skid;
  logic            load_skid_in;

  // ---------------------------------------------------------------------
  // Immediate field slicing toward the extender
  // ---------------------------------------------------------------------
  assign opcode     = in_instr_i[6:0];
  assign ext_type_o = opcode;

  always_comb begin
    ext_imm_o  = 12'h000;
    in_illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: ext_imm_o = in_instr_i[31:20];
      OP_STORE:                 ext_imm_o = {in_instr_i[31:25], in_instr_i[11:7]};
      OP_BRNCH:                 ext_imm_o = {in_instr_i[31], in_instr_i[7],
                                             in_instr_i[30:25], in_instr_i[11:8]};
      OP_REG:                   ext_imm_o = 12'h000;
      default:                  in_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Handshakes and buffer FSM
  // ---------------------------------------------------------------------
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = in_ready_q;

  assign accept  = in_valid_i && in_ready_q && !flush_i;
  assign deliver = out_valid_o && out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_i) begin
      // Flush wins over any same-cycle accept or deliver.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            load_head_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d      = ST_FULL;
            load_skid_in = 1'b1;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready_o is low here, so only a deliver can happen.
          if (deliver) begin
            state_d        = ST_ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered ready follows the next state so it is valid right after the edge.
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_instr_q <= '0;
      head_imm_q   <= '0;
      head_ill_q   <= 1'b0;
    end else if (load_head_in) begin
      head_instr_q <= in_instr_i;
      head_imm_q   <= ext_imm_i;
      head_ill_q   <= in_illegal;
    end else if (load_head_skid) begin
      head_instr_q <= skid_instr_q;
      head_imm_q   <= skid_imm_q;
      head_ill_q   <= skid_ill_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skid_instr_q <= '0;
      skid_imm_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else if (load_skid_in) begin
      skid_instr_q <= in_instr_i;
      skid_imm_q   <= ext_imm_i;
      skid_ill_q   <= in_illegal;
    end
  end

  assign out_instr_o   = head_instr_q;
  assign out_imm_o     = head_imm_q;
  assign out_illegal_o = head_ill_q;

  // ---------------------------------------------------------------------
  // Stall counter: saturating, survives flush
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= 16'h0000;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_imm_stage_ctrl.sv
// Purpose: directed bench for imm_stage_ctrl with a behavioural sign extender.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: out_ready_i is driven directly by the directed sequence.
module tb_imm_stage_ctrl;

  logic        clk_i;
  logic        rst_n_i;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] in_instr_i;
  logic        in_ready_o;
  logic [11:0] ext_imm_o;
  logic [6:0]  ext_type_o;
  logic [31:0] ext_imm_i;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic [31:0] out_imm_o;
  logic        out_illegal_o;
  logic        out_ready_i;
  logic [15:0] stall_cnt_o;

  int compared;
  int mismatched;

  imm_stage_ctrl #(.XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_instr_i   (in_instr_i),
    .in_ready_o   (in_ready_o),
    .ext_imm_o    (ext_imm_o),
    .ext_type_o   (ext_type_o),
    .ext_imm_i    (ext_imm_i),
    .out_valid_o  (out_valid_o),
    .out_instr_o  (out_instr_o),
    .out_imm_o    (out_imm_o),
    .out_illegal_o(out_illegal_o),
    .out_ready_i  (out_ready_i),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Extender model: branch offsets carry an implicit zero LSB.
  always_comb begin
    if (ext_type_o == 7'b1100011)
      ext_imm_i = {{19{ext_imm_o[11]}}, ext_imm_o, 1'b0};
    else
      ext_imm_i = {{20{ext_imm_o[11]}}, ext_imm_o};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n_i    = 1'b0;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    in_instr_i = 32'h0;
    out_ready_i = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready",  {31'd0, in_ready_o},    32'd1);
    chk("rst_out_valid", {31'd0, out_valid_o},   32'd0);
    chk("rst_instr",     out_instr_o,            32'd0);
    chk("rst_imm",       out_imm_o,              32'd0);
    chk("rst_illegal",   {31'd0, out_illegal_o}, 32'd0);
    chk("rst_stall",     {16'd0, stall_cnt_o},   32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Streaming I, S, B with ready high
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00500093;
    #1;
    chk("i_ext_imm",  {20'd0, ext_imm_o},  32'h005);
    chk("i_ext_type", {25'd0, ext_type_o}, 32'h13);
    tick();
    chk("i_valid", {31'd0, out_valid_o}, 32'd1);
    chk("i_instr", out_instr_o, 32'h00500093);
    chk("i_imm",   out_imm_o,   32'h00000005);
    in_instr_i = 32'hFE112E23;
    #1;
    chk("s_ext_imm", {20'd0, ext_imm_o}, 32'hFFC);
    tick();
    chk("s_instr", out_instr_o, 32'hFE112E23);
    chk("s_imm",   out_imm_o,   32'hFFFFFFFC);
    in_instr_i = 32'hFE0008E3;
    #1;
    chk("b_ext_imm", {20'd0, ext_imm_o}, 32'hFF8);
    tick();
    chk("b_instr", out_instr_o, 32'hFE0008E3);
    chk("b_imm",   out_imm_o,   32'hFFFFFFF0);
    in_valid_i = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid_o}, 32'd0);
    chk("drain_stall", {16'd0, stall_cnt_o}, 32'd0);

    // Stall: two accepts fill the buffer
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00A00113;
    tick();
    chk("st1_ready", {31'd0, in_ready_o},  32'd1);
    chk("st1_valid", {31'd0, out_valid_o}, 32'd1);
    in_instr_i = 32'h00B00193;
    tick();
    chk("full_ready", {31'd0, in_ready_o},  32'd0);
    chk("full_stall", {16'd0, stall_cnt_o}, 32'd1);
    in_instr_i = 32'h00C00213;
    tick();
    chk("hold_instr", out_instr_o, 32'h00A00113);
    chk("hold_imm",   out_imm_o,   32'h0000000A);
    chk("hold_stall", {16'd0, stall_cnt_o}, 32'd2);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("pop1_instr", out_instr_o, 32'h00B00193);
    chk("pop1_imm",   out_imm_o,   32'h0000000B);
    chk("pop1_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    chk("pop2_valid", {31'd0, out_valid_o}, 32'd0);
    chk("pop2_stall", {16'd0, stall_cnt_o}, 32'd2);

    // R type and an illegal opcode
    in_valid_i = 1'b1;
    in_instr_i = 32'h002081B3;
    #1;
    chk("r_ext_imm", {20'd0, ext_imm_o}, 32'h000);
    tick();
    chk("r_instr",   out_instr_o, 32'h002081B3);
    chk("r_illegal", {31'd0, out_illegal_o}, 32'd0);
    in_instr_i = 32'hFFF0007F;
    #1;
    chk("x_ext_imm", {20'd0, ext_imm_o}, 32'h000);
    tick();
    chk("x_illegal", {31'd0, out_illegal_o}, 32'd1);
    chk("x_imm",     out_imm_o, 32'h0);
    in_valid_i = 1'b0;
    tick();

    // Flush while full with a word on the input
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00100093;
    tick();
    in_instr_i = 32'h00200093;
    tick();
    chk("pre_flush_ready", {31'd0, in_ready_o}, 32'd0);
    in_instr_i = 32'h00300093;
    flush_i    = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_ready", {31'd0, in_ready_o},  32'd1);
    chk("flush_stall", {16'd0, stall_cnt_o}, 32'd4);
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("post_flush_valid", {31'd0, out_valid_o}, 32'd0);

    // Asynchronous reset while one entry is held
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00700393;
    tick();
    chk("one_valid", {31'd0, out_valid_o}, 32'd1);
    in_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_valid",   {31'd0, out_valid_o},   32'd0);
    chk("arst_ready",   {31'd0, in_ready_o},    32'd1);
    chk("arst_instr",   out_instr_o,            32'd0);
    chk("arst_imm",     out_imm_o,              32'd0);
    chk("arst_illegal", {31'd0, out_illegal_o}, 32'd0);
    chk("arst_stall",   {16'd0, stall_cnt_o},   32'd0);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);

    // Stall counter saturation
    in_valid_i = 1'b1;
    in_instr_i = 32'h00800413;
    tick();
    in_valid_i = 1'b0;
    chk("sat_start", {16'd0, stall_cnt_o}, 32'd0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", {16'd0, stall_cnt_o}, 32'h0000FFFE);
    tick();
    chk("sat_ffff", {16'd0, stall_cnt_o}, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold",  {16'd0, stall_cnt_o}, 32'h0000FFFF);
    chk("sat_instr", out_instr_o, 32'h00800413);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imm_stage_ctrl.md
# imm_stage_ctrl

Decode-stage sequencer for the 12-bit immediate sign extender in the RISC-V pipeline. It accepts instructions from the IF/ID register over a valid/ready handshake and slices the I/S/B immediate field by opcode. It drives the sign extender combinationally and captures its 32-bit result. Instruction and immediate are held in a two-entry skid buffer that feeds the ID/EX register, with pipeline stall and flush support.

## Interface
Parameters:
- XLEN, 32, instruction and immediate width; only 32 is supported.

Ports:
- clk_i  input  1  pipeline clock; all state updates on the rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- flush_i  input  1  branch/exception flush; discards buffered and incoming instructions.
- in_valid_i  input  1  IF/ID presents an instruction.
- in_instr_i  input  32  instruction word.
- in_ready_o  output  1  stage can accept; registered.
- ext_imm_o  output  12  immediate field to the sign extender (combinational from in_instr_i).
- ext_type_o  output  7  opcode to the sign extender, equal to in_instr_i[6:0].
- ext_imm_i  input  32  sign-extended result returned by the extender (combinational).
- out_valid_o  output  1  head entry valid toward ID/EX.
- out_instr_o  output  32  head entry instruction.
- out_imm_o  output  32  head entry extended immediate.
- out_illegal_o  output  1  head entry opcode is not an I/S/B/R type.
- out_ready_i  input  1  ID/EX accepts the head entry (low = stall).
- stall_cnt_o  output  16  count of cycles with out_valid_o=1 and out_ready_i=0; saturating.

## Operation
- Field slicing (ext_imm_o):
  - I types (0000011, 0010011, 1100111): instr[31:20].
  - S type (0100011): {instr[31:25], instr[11:7]}.
  - B type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8]}.
  - All other opcodes: 12'h000.
- illegal flag: set when the opcode is none of the five above and not R type (0110011).
- Accept: in_valid_i && in_ready_o && !flush_i at a clock edge. The entry {in_instr_i, ext_imm_i, illegal} is written at that edge.
- Deliver: out_valid_o && out_ready_i at a clock edge. The head pops and the second entry, if any, becomes head.
- Buffer FSM states: EMPTY, ONE, FULL (two entries). Transitions:
  - EMPTY: accept goes to ONE.
  - ONE: accept without deliver goes to FULL; deliver without accept goes to EMPTY; accept with deliver stays ONE, with the new entry becoming head.
  - FULL: deliver goes to ONE; no accept is possible.
- in_ready_o is registered and equals 1 in states EMPTY and ONE.
- out_valid_o equals 1 in states ONE and FULL.
- Entry order is strict FIFO; no reordering.
- Flush: the FSM goes to EMPTY at that edge. Any same-cycle accept or deliver is ignored for state purposes, although downstream may still sample the head that cycle. Flush has priority over all other events.
- stall_cnt_o increments on each edge where out_valid_o=1 and out_ready_i=0. It saturates at 16'hFFFF and is not cleared by flush.

## Timing
- Reset values (asserted rst_n_i):
  - State EMPTY.
  - in_ready_o=1, out_valid_o=0.
  - out_instr_o=0, out_imm_o=0, out_illegal_o=0.
  - stall_cnt_o=0.
  - Reset assertion mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an instruction accepted at edge k is visible on out_* after edge k (one cycle), provided the buffer was EMPTY.
- Throughput: one instruction per cycle while out_ready_i=1.
- Stall tolerance: when out_ready_i drops, the skid entry absorbs the in-flight instruction. in_ready_o falls after the edge at which the buffer becomes FULL; no instruction is lost or duplicated.
- ext_imm_o and ext_type_o have a purely combinational path from in_instr_i. The extender result must settle within the same cycle.
- Head outputs are stable while out_valid_o=1 and out_ready_i=0.
- Values on out_instr_o, out_imm_o and out_illegal_o when out_valid_o=0 are don't-care.

## Test plan
- Reset, then stream of three instructions 0x00500093, 0xFE112E23, 0xFE0008E3 with out_ready_i=1. Each output appears one cycle after acceptance, with imm 0x00000005, 0xFFFFFFFC and 0xFFFFFFF0 respectively.
- Two accepts with out_ready_i held 0 → buffer goes FULL and in_ready_o=0. Raise out_ready_i → entries delivered in order with no drop. stall_cnt_o equals the number of held cycles.
- Opcode 0110011 → ext_imm_o=0 and out_illegal_o=0. Opcode 1111111 → out_illegal_o=1.
- flush_i while FULL and in_valid_i=1 → next cycle out_valid_o=0 and in_ready_o=1; the incoming instruction is not stored.
- rst_n_i pulsed low between edges while ONE → out_valid_o=0 immediately, with all outputs at their reset values.
- Hold the stall long enough to reach 65535 stall cycles → stall_cnt_o stays at 16'hFFFF.
